// File: rtl/pad_cfg_ctrl_pkg.sv
// ============================================================================
// Module      : pad_cfg_pkg
// Description : Shared constants and types for the pad configuration controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pad_cfg_pkg;

    localparam int N_PADS = 48;
    localparam int CFG_W  = 6;

    localparam logic [5:0] LOCK_ADDR = 6'd63;

    typedef logic [CFG_W-1:0] pad_cfg_t;

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t WALK = 1'b1;

endpackage

`default_nettype wire

// File: rtl/pad_cfg_ctrl_if.sv
// ============================================================================
// Module      : pad_cfg_ctrl_if
// Description : Register port, apply handshake and pad-frame vector bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pad_cfg_ctrl_if;
    import pad_cfg_pkg::*;

    logic                      req;
    logic                      we;
    logic [5:0]                addr;
    pad_cfg_t                  wdata;
    logic                      gnt;
    logic                      rvalid;
    pad_cfg_t                  rdata;
    logic                      err;
    logic                      apply;
    logic                      busy;
    logic                      done;
    logic [N_PADS*CFG_W-1:0]   pad_cfg;

    modport master (
        output req, we, addr, wdata, apply,
        input  gnt, rvalid, rdata, err, busy, done, pad_cfg
    );

    modport slave (
        input  req, we, addr, wdata, apply,
        output gnt, rvalid, rdata, err, busy, done, pad_cfg
    );

endinterface

`default_nettype wire

// File: rtl/pad_cfg_ctrl.sv
// ============================================================================
// Module      : pad_cfg_ctrl
// Description : Shadow/active pad configuration store with staggered apply walk.
//               Optional lock register enabled by defining PAD_CFG_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pad_cfg_ctrl
    import pad_cfg_pkg::*;
#(
    parameter int STAGGER = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    pad_cfg_ctrl_if.slave bus
);

    localparam int              GAP_W      = $clog2(STAGGER + 1);
    localparam logic [GAP_W-1:0] c_gap_last = GAP_W'(STAGGER - 1);
    localparam logic [5:0]      c_idx_last = 6'(N_PADS - 1);

    pad_cfg_t         r_shadow [N_PADS];
    pad_cfg_t         r_active [N_PADS];

    logic             r_rvalid;
    logic             r_err;
    pad_cfg_t         r_rdata;

    state_t           r_state;
    logic [5:0]       r_idx;
    logic [GAP_W-1:0] r_gap;
    logic             r_pending;
    logic             r_done;

    logic             w_in_range;
    logic             w_lock_hit;
    pad_cfg_t         w_lock_word;
    logic             w_err;
    logic             w_apply;
    logic             w_wr_en;
    pad_cfg_t         w_rd_data;

    assign w_in_range = (bus.addr < 6'(N_PADS));

`ifdef PAD_CFG_LOCK_EN
    logic r_lock;

    // Once locked, every write (including to the lock itself) is rejected.
    assign w_lock_hit  = (bus.addr == LOCK_ADDR);
    assign w_lock_word = {{(CFG_W-1){1'b0}}, r_lock};
    assign w_err       = (!w_in_range && !w_lock_hit) || (bus.we && r_lock);
    assign w_apply     = bus.apply && !r_lock;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock <= 1'b0;
        end else if (bus.req && bus.we && w_lock_hit && !w_err && bus.wdata[0]) begin
            r_lock <= 1'b1;
        end
    end
`else
    assign w_lock_hit  = 1'b0;
    assign w_lock_word = '0;
    assign w_err       = !w_in_range;
    assign w_apply     = bus.apply;
`endif

    assign w_wr_en   = bus.req && bus.we && !w_err && w_in_range;
    assign w_rd_data = w_lock_hit ? w_lock_word :
                       (w_in_range ? r_shadow[bus.addr] : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= bus.req;
            r_err    <= bus.req && w_err;
            r_rdata  <= (bus.req && !bus.we && !w_err) ? w_rd_data : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_PADS; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_shadow[bus.addr] <= bus.wdata;
        end
    end

    // Walker: one pad copied on the first cycle of each STAGGER-cycle slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_gap     <= '0;
            r_pending <= 1'b0;
            r_done    <= 1'b0;
            for (int i = 0; i < N_PADS; i++) begin
                r_active[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_apply || r_pending) begin
                        r_state   <= WALK;
                        r_idx     <= '0;
                        r_gap     <= '0;
                        r_pending <= 1'b0;
                    end
                end
                WALK: begin
                    if (w_apply) begin
                        r_pending <= 1'b1;
                    end
                    if (r_gap == '0) begin
                        r_active[r_idx] <= r_shadow[r_idx];
                    end
                    if (r_gap == c_gap_last) begin
                        r_gap <= '0;
                        if (r_idx == c_idx_last) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 6'd1;
                        end
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gnt    = bus.req;
    assign bus.rvalid = r_rvalid;
    assign bus.err    = r_err;
    assign bus.rdata  = r_rdata;
    assign bus.busy   = (r_state == WALK);
    assign bus.done   = r_done;

    for (genvar g = 0; g < N_PADS; g++) begin : g_pack
        assign bus.pad_cfg[g*CFG_W +: CFG_W] = r_active[g];
    end

endmodule

`default_nettype wire

// File: tb/tb_pad_cfg_ctrl.sv
// ============================================================================
// Module      : tb_pad_cfg_ctrl
// Description : Directed self-checking bench for pad_cfg_ctrl (STAGGER = 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pad_cfg_ctrl;
    import pad_cfg_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pad_cfg_ctrl_if bus();

    pad_cfg_ctrl #(.STAGGER(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    int busy_cnt = 0;

    typedef struct {
        logic       we;
        logic [5:0] addr;
        pad_cfg_t   wdata;
        logic       exp_err;
        pad_cfg_t   exp_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic pad_cfg_t pad(input int k);
        return bus.pad_cfg[k*CFG_W +: CFG_W];
    endfunction

    // Called at a negedge; returns at the following negedge with the response checked.
    task automatic access(input logic we, input logic [5:0] addr, input pad_cfg_t wdata,
                          input logic exp_err, input pad_cfg_t exp_rdata, input string name);
        bus.req   = 1'b1;
        bus.we    = we;
        bus.addr  = addr;
        bus.wdata = wdata;
        #1 check({name, ".gnt"}, 64'(bus.gnt), 64'd1);
        @(negedge clk);
        bus.req = 1'b0;
        check({name, ".rvalid"}, 64'(bus.rvalid), 64'd1);
        check({name, ".err"},    64'(bus.err),    64'(exp_err));
        check({name, ".rdata"},  64'(bus.rdata),  64'(exp_rdata));
    endtask

    task automatic add_vec(input logic we, input logic [5:0] addr, input pad_cfg_t wdata,
                           input logic exp_err, input pad_cfg_t exp_rdata);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.exp_err = exp_err; v.exp_rdata = exp_rdata;
        vecs.push_back(v);
    endtask

    initial begin
        rst       = 1'b1;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.apply = 1'b0;

        for (int a = 0; a < N_PADS; a++) add_vec(1'b0, 6'(a), 6'h00, 1'b0, 6'h00);
        add_vec(1'b1, 6'd5,  6'h2A, 1'b0, 6'h00);
        add_vec(1'b0, 6'd5,  6'h00, 1'b0, 6'h2A);
        add_vec(1'b1, 6'd47, 6'h15, 1'b0, 6'h00);
        add_vec(1'b0, 6'd47, 6'h00, 1'b0, 6'h15);
        add_vec(1'b0, 6'd48, 6'h00, 1'b1, 6'h00);
        add_vec(1'b1, 6'd48, 6'h3F, 1'b1, 6'h00);
        add_vec(1'b0, 6'd48, 6'h00, 1'b1, 6'h00);
`ifdef PAD_CFG_LOCK_EN
        add_vec(1'b0, 6'd63, 6'h00, 1'b0, 6'h00);
        add_vec(1'b1, 6'd63, 6'h00, 1'b0, 6'h00);
`else
        add_vec(1'b0, 6'd63, 6'h00, 1'b1, 6'h00);
        add_vec(1'b1, 6'd63, 6'h3F, 1'b1, 6'h00);
`endif
        add_vec(1'b0, 6'd6,  6'h00, 1'b0, 6'h00);
        add_vec(1'b0, 6'd5,  6'h00, 1'b0, 6'h2A);

        repeat (3) @(negedge clk);
        check("reset.rvalid", 64'(bus.rvalid), 64'd0);
        check("reset.err",    64'(bus.err),    64'd0);
        check("reset.rdata",  64'(bus.rdata),  64'd0);
        check("reset.busy",   64'(bus.busy),   64'd0);
        check("reset.done",   64'(bus.done),   64'd0);
        check("reset.pad_cfg_zero", 64'(bus.pad_cfg == '0), 64'd1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_err,
                   vecs[i].exp_rdata, $sformatf("vec%0d", i));
        end
        @(negedge clk);
        check("idle.rvalid", 64'(bus.rvalid), 64'd0);
        check("no_apply.pad_cfg_zero", 64'(bus.pad_cfg == '0), 64'd1);

        // Three back-to-back walks: mid-walk re-apply, then apply on the completion edge.
        bus.apply = 1'b1;
        for (int e = 0; e <= 582; e++) begin
            @(posedge clk);
            @(negedge clk);
            bus.apply = 1'b0;
            if (bus.busy) busy_cnt++;
            case (e)
                0:   check("w0.busy", 64'(bus.busy), 64'd1);
                20:  check("w1.pad5_before", 64'(pad(5)), 64'h00);
                21:  check("w1.pad5_after",  64'(pad(5)), 64'h2A);
                50:  begin bus.req = 1'b1; bus.we = 1'b1; bus.addr = 6'd0;  bus.wdata = 6'h01; end
                51:  begin
                         check("w1.wr0.err", 64'(bus.err), 64'd0);
                         bus.addr = 6'd40; bus.wdata = 6'h3F;
                     end
                52:  begin
                         check("w1.wr40.rvalid", 64'(bus.rvalid), 64'd1);
                         bus.req = 1'b0;
                     end
                100: bus.apply = 1'b1;
                120: bus.apply = 1'b1;
                160: check("w1.pad40_before", 64'(pad(40)), 64'h00);
                161: check("w1.pad40_after",  64'(pad(40)), 64'h3F);
                188: check("w1.pad47_before", 64'(pad(47)), 64'h00);
                189: check("w1.pad47_after",  64'(pad(47)), 64'h15);
                191: begin
                         check("w1.busy_last", 64'(bus.busy), 64'd1);
                         check("w1.done_early", 64'(bus.done), 64'd0);
                     end
                192: begin
                         check("w1.done",  64'(bus.done), 64'd1);
                         check("w1.busy_drop", 64'(bus.busy), 64'd0);
                         check("w1.pad0_old", 64'(pad(0)), 64'h00);
                     end
                193: begin
                         check("w2.rewalk_busy", 64'(bus.busy), 64'd1);
                         check("w2.done_pulse", 64'(bus.done), 64'd0);
                     end
                194: check("w2.pad0_new", 64'(pad(0)), 64'h01);
                384: bus.apply = 1'b1;
                385: begin
                         check("w2.done", 64'(bus.done), 64'd1);
                         check("w2.busy_drop", 64'(bus.busy), 64'd0);
                     end
                386: check("w3.rewalk_busy", 64'(bus.busy), 64'd1);
                578: begin
                         check("w3.done", 64'(bus.done), 64'd1);
                         check("w3.busy_drop", 64'(bus.busy), 64'd0);
                     end
                579: check("w3.done_pulse", 64'(bus.done), 64'd0);
                582: check("w3.idle", 64'(bus.busy), 64'd0);
                default: ;
            endcase
        end
        check("walk.busy_cycles", 64'(busy_cnt), 64'd576);
        check("walk.pad40_final", 64'(pad(40)), 64'h3F);

        // Reset in the middle of a walk.
        bus.apply = 1'b1;
        @(negedge clk);
        bus.apply = 1'b0;
        repeat (30) @(negedge clk);
        check("midrst.busy_before", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst.busy",  64'(bus.busy), 64'd0);
        check("midrst.done",  64'(bus.done), 64'd0);
        check("midrst.pad_cfg_zero", 64'(bus.pad_cfg == '0), 64'd1);
        access(1'b0, 6'd5,  6'h00, 1'b0, 6'h00, "midrst.rd5");
        access(1'b0, 6'd40, 6'h00, 1'b0, 6'h00, "midrst.rd40");

`ifdef PAD_CFG_LOCK_EN
        access(1'b1, 6'd63, 6'h01, 1'b0, 6'h00, "lock.set");
        access(1'b0, 6'd63, 6'h00, 1'b0, 6'h01, "lock.rd");
        access(1'b1, 6'd3,  6'h0A, 1'b1, 6'h00, "lock.wr3");
        access(1'b1, 6'd63, 6'h00, 1'b1, 6'h00, "lock.wrlock");
        access(1'b0, 6'd3,  6'h00, 1'b0, 6'h00, "lock.rd3");
        bus.apply = 1'b1;
        @(negedge clk);
        bus.apply = 1'b0;
        check("lock.apply_ignored", 64'(bus.busy), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        access(1'b0, 6'd63, 6'h00, 1'b0, 6'h00, "lock.rd_after_rst");
        access(1'b1, 6'd3,  6'h0A, 1'b0, 6'h00, "lock.wr3_after_rst");
        access(1'b0, 6'd3,  6'h00, 1'b0, 6'h0A, "lock.rd3_after_rst");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pad_cfg_ctrl.md
# pad_cfg_ctrl

- Owns the 48×6-bit pad configuration vector that drives the chip pad frame (bit 0 of each entry drives the pad pull enable, active-low).
- Software-visible shadow copy written over a simple req/gnt register port.
- On an apply command, shadow values are copied into the active vector one pad every STAGGER cycles, so pull/drive changes never switch all pads in the same cycle.
- Sits between the SoC peripheral interconnect and the pad frame.

## Interface
Parameters:
- N_PADS, 48, number of pad configuration entries
- CFG_W, 6, bits per pad entry
- STAGGER, 4, cycles per pad during an apply walk (≥1)

Ports:
- clk_i  in  1  block clock
- rst_i  in  1  synchronous, active-high reset
- req_i  in  1  register access request
- we_i  in  1  1 = write, 0 = read
- addr_i  in  6  pad index (63 = lock register when enabled)
- wdata_i  in  CFG_W  write data
- gnt_o  out  1  access accepted (combinational, equals req_i)
- rvalid_o  out  1  response valid, one cycle after grant
- rdata_o  out  CFG_W  read data from shadow
- err_o  out  1  response error, qualified by rvalid_o
- apply_i  in  1  single-cycle pulse: start shadow→active walk
- busy_o  out  1  walk in progress
- done_o  out  1  single-cycle pulse on walk completion
- pad_cfg_o  out  N_PADS×CFG_W  active configuration to pad frame

## Operation
- Reset values:
  - shadow and active all zero
  - rvalid_o, err_o, busy_o, done_o = 0
  - rdata_o = 0
  - state IDLE, pending = 0
- Register port:
  - Every req_i is granted the same cycle.
  - The response appears on the next cycle: rvalid_o = 1, rdata_o = shadow[addr] for reads, 0 for writes.
  - addr_i ≥ N_PADS (other than the enabled lock address): err_o = 1, rdata_o = 0, write dropped.
  - A write updates the shadow on the grant edge.
  - A read in the cycle after a write to the same address returns the new value.
- FSM states: IDLE, WALK.
  - IDLE → WALK on apply_i. Pad index idx = 0, gap counter = 0, busy_o = 1.
  - In WALK, when gap = 0: active[idx] ← shadow[idx] at that edge.
  - gap counts 0..STAGGER-1. At gap wrap, idx increments.
  - After idx = N_PADS-1 wraps: return to IDLE, done_o pulses, busy_o drops the same cycle.
- Shadow writes are accepted during WALK. Entries not yet walked pick up the new value; entries already walked keep their old active value until the next apply.
- apply_i during WALK sets pending. When the walk completes with pending set, done_o still pulses and the FSM re-enters WALK the next cycle with idx = 0 (busy_o low exactly one cycle). Multiple applies during one walk collapse into one pending.
- apply_i in the same cycle as the completion edge counts as pending.
- Reset mid-walk: everything returns to reset values immediately, including active.

## Timing
- Register read latency: 1 cycle. Back-to-back requests are supported every cycle.
- Walk duration: N_PADS×STAGGER cycles.
- Pad k updates exactly 1 + k×STAGGER edges after the apply_i edge.
- done_o is asserted in the cycle after the last gap cycle.
- pad_cfg_o is driven directly from registers (no combinational path from the port).

## Configuration
- PAD_CFG_LOCK_EN defined:
  - Address 63 is the lock register, readable as {CFG_W-1 zeros, lock}.
  - Writing bit 0 = 1 sets lock. Lock clears only on rst_i.
  - While locked: every shadow write and lock-register write returns err_o = 1 and is dropped; apply_i is ignored. Reads still succeed.
- Macro undefined: no lock register; address 63 behaves as out of range (err_o = 1); apply_i is always honoured.

## Structure
- Package pad_cfg_pkg holds:
  - N_PADS and CFG_W constants
  - LOCK_ADDR = 6'd63
  - pad_cfg_t (logic [CFG_W-1:0])
  - state enum {IDLE, WALK}
- No sub-module. Register front end and walker are a single module. The walker counters are local (idx 6 bits, gap $clog2(STAGGER+1) bits).

## Test plan
- Reset, then read addr 0..47: rdata_o = 0, err_o = 0. pad_cfg_o all zero.
- Write pad 5 = 6'h2A, pad 47 = 6'h15; read back both next cycle; pad_cfg_o unchanged (no apply).
- apply_i with STAGGER = 4: pad 5 changes at edge 21; pad 47 changes at edge 189; done_o at cycle 192; busy_o high for 192 cycles.
- During a walk, write pad 0 (already walked) = 6'h01 and pad 40 = 6'h3F. Pad 40 is applied and pad 0 is not. A second apply_i mid-walk causes an automatic re-walk, after which pad 0 = 6'h01.
- Access to addr 48 and addr 63 (macro off): err_o = 1, rdata_o = 0, no shadow change.
- With PAD_CFG_LOCK_EN: write addr 63 = 1. A subsequent write to pad 3 gives err_o = 1, and apply_i gives busy_o = 0. After rst_i, lock = 0.
